dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- MEM-stage sequencer for variable-latency data memory in the 5-stage RISC-V pipeline.
- Turns each load or store in MEM into a req/ack transaction.
- Freezes the upstream pipeline (PC through EX/MEM) and injects bubbles into MEM/WB while the access is outstanding.
- Presents captured load data to MEM/WB on completion; bus errors and timeouts are reported as faults.

Parameters:
- TIMEOUT, 255, REQ-state cycles without ack before fault (1..2^TO_W-1).
- TO_W, 8, timeout counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- mem_valid_in  in  1  valid instruction in MEM stage
- mem_read_in  in  1  instruction is a load
- mem_write_in  in  1  instruction is a store
- mem_addr_in  in  32  byte address from EX/MEM
- mem_wdata_in  in  32  store data, lane-aligned
- mem_be_in  in  4  byte enables
- dmem_req_o  out  1  request to data memory
- dmem_we_o  out  1  1=write, 0=read
- dmem_addr_o  out  32  request address
- dmem_wdata_o  out  32  write data
- dmem_be_o  out  4  byte enables
- dmem_ack_i  in  1  transaction complete
- dmem_rdata_i  in  32  read data, valid with ack
- dmem_err_i  in  1  bus error, qualified by ack
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- wb_bubble_o  out  1  force MEM/WB reg_write_en and mem_to_reg to 0 this cycle
- load_data_o  out  32  load result feeding MEM/WB load-data input
- access_done_o  out  1  1-cycle pulse: access retires this cycle
- fault_o  out  1  1-cycle pulse alongside access_done_o on error/timeout
- fault_addr_o  out  32  address of last faulting access

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
  - All outputs 0, state IDLE, timeout counter 0.
  - Reset during REQ drops dmem_req_o immediately (asynchronous); the transaction is abandoned and a late ack is ignored.
- access = mem_valid_in & (mem_read_in | mem_write_in).
  - If read and write are both set, treat as a store; no fault is raised.
- FSM states IDLE, REQ, DONE; state register is the only source of dmem_req_o, so the request is glitch-free.
- IDLE:
  - access=1: stall_o=1 combinationally in the same cycle.
  - Register mem_addr_in, mem_wdata_in and mem_be_in into dmem_addr_o, dmem_wdata_o and dmem_be_o.
  - Set dmem_we_o = mem_write_in; clear the counter; next state REQ.
  - access=0: stall_o=0, stay in IDLE.
- REQ:
  - dmem_req_o=1, stall_o=1; dmem_* outputs held stable.
  - Counter increments each cycle without ack.
  - ack & !err: load_data_o <= dmem_rdata_i if read, else unchanged; next state DONE.
  - ack & err, or counter==TIMEOUT-1 without ack: load_data_o <= 0, fault_addr_o <= dmem_addr_o, fault flag set, next state DONE.
  - Ack takes priority over timeout in the same cycle.
  - dmem_req_o deasserts on the cycle after ack.
- DONE:
  - dmem_req_o=0, stall_o=0, access_done_o=1; fault_o=1 if the fault flag is set.
  - Pipeline advances at the end of this cycle.
  - Next state IDLE unconditionally. The instruction still present in MEM during DONE is the retiring one and must not retrigger.
- wb_bubble_o = stall_o.
- Latency for an ack arriving k cycles after REQ entry (k=0 means ack in the first REQ cycle): load/store occupies MEM for k+3 cycles; stall_o is high for k+2 of them.
- Non-memory instruction in IDLE: zero added latency, no outputs change.
- Back-to-back memory ops: DONE→IDLE→REQ; the second access stalls from its IDLE cycle.
- dmem_ack_i outside REQ is ignored.
- fault_addr_o holds until the next fault; load_data_o holds until the next read ack or fault.

Test Plan:
- Zero-wait load, addr 0x100, ack+rdata 0xDEADBEEF in the first REQ cycle → stall_o high 2 cycles; DONE cycle has load_data_o=0xDEADBEEF, access_done_o=1, fault_o=0.
- Store, addr 0x204, wdata 0x12345678, be 4'b1111, ack after 3 wait cycles → dmem_req_o/we_o high 4 cycles with stable addr/data; stall_o high 5 cycles; load_data_o unchanged.
- Two consecutive loads (rdata 0x11, then 0x22) → two distinct req pulses separated by at least 1 idle cycle; access_done_o pulses twice; values 0x11 then 0x22.
- Load with no ack, TIMEOUT=4 → REQ for 4 cycles, then DONE with fault_o=1, fault_addr_o=access address, load_data_o=0; a later ack is ignored.
- Ack with err on load at 0xBAD0 → fault_o=1, fault_addr_o=0xBAD0, load_data_o=0.
- rst_n low in 2nd REQ cycle → dmem_req_o and stall_o 0 immediately; after release, IDLE with no spurious done or fault.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: data-memory req/ack bus between the MEM-stage sequencer and memory
//   master: req, we, addr, wdata, be out; ack, rdata, err in
//   slave : the mirror image
interface dmem_access_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  modport master (output req, we, addr, wdata, be, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata, err);
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage sequencer turning loads/stores into req/ack transactions with pipeline freeze
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_*_in            instruction currently in MEM (valid, read, write, addr, wdata, be)
//   bus                 data-memory bus (master side)
//   stall_o             freeze PC through EX/MEM
//   wb_bubble_o         squash MEM/WB writeback this cycle
//   load_data_o         captured load result
//   access_done_o       access retires this cycle
//   fault_o             retiring access hit a bus error or timeout
//   fault_addr_o        address of the last faulting access
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_valid_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic [31:0]         mem_addr_in,
  input  logic [31:0]         mem_wdata_in,
  input  logic [3:0]          mem_be_in,
  dmem_access_ctrl_if.master  bus,
  output logic                stall_o,
  output logic                wb_bubble_o,
  output logic [31:0]         load_data_o,
  output logic                access_done_o,
  output logic                fault_o,
  output logic [31:0]         fault_addr_o
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t          state_q, state_d;
  logic            we_q, we_d, fault_q, fault_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, load_q, load_d, faddr_q, faddr_d;
  logic [3:0]      be_q, be_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            access, tmo;
  assign access = mem_valid_in & (mem_read_in | mem_write_in);
  assign tmo    = cnt_q == TO_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    load_d  = load_q;
    faddr_d = faddr_q;
    case (state_q)
      IDLE: if (access) begin
        state_d = REQ;
        we_d    = mem_write_in;
        addr_d  = mem_addr_in;
        wdata_d = mem_wdata_in;
        be_d    = mem_be_in;
        cnt_d   = '0;
        fault_d = 1'b0;
      end
      REQ: begin
        // ack wins over a timeout landing in the same cycle
        if (bus.ack && !bus.err) begin
          state_d = DONE;
          load_d  = we_q ? load_q : bus.rdata;
        end else if (bus.ack || tmo) begin
          state_d = DONE;
          load_d  = '0;
          faddr_d = addr_q;
          fault_d = 1'b1;
        end else cnt_d = cnt_q + TO_W'(1);
      end
      // the instruction still sitting in MEM here is the retiring one, so never re-arm from DONE
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      load_q  <= '0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      load_q  <= load_d;
      faddr_q <= faddr_d;
    end
  assign bus.req       = state_q == REQ;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.be        = be_q;
  // stall raised combinationally in IDLE so the pipeline freezes on the access's first cycle; held low in reset
  assign stall_o       = rst_n & ((state_q == IDLE && access) || state_q == REQ);
  assign wb_bubble_o   = stall_o;
  assign load_data_o   = load_q;
  assign access_done_o = state_q == DONE;
  assign fault_o       = state_q == DONE && fault_q;
  assign fault_addr_o  = faddr_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed self-checking bench for dmem_access_ctrl with TIMEOUT=4
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, rd, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        stall, bubble, done, fault;
  logic [31:0] ld, faddr;
  int          errors = 0;
  int          checks = 0;
  dmem_access_ctrl_if bus ();
  dmem_access_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_in(valid), .mem_read_in(rd), .mem_write_in(wr),
    .mem_addr_in(addr), .mem_wdata_in(wdata), .mem_be_in(be),
    .bus(bus),
    .stall_o(stall), .wb_bubble_o(bubble), .load_data_o(ld),
    .access_done_o(done), .fault_o(fault), .fault_addr_o(faddr)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_mem(input logic v, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    valid = v; rd = r; wr = w; addr = a; wdata = d; be = b;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    set_mem(0, 0, 0, 0, 0, 0);
    bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = '0;
    #3;
    chk("rst_req", bus.req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ld", ld, 0);
    chk("rst_faddr", faddr, 0);
    chk("rst_addr", bus.addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // non-memory instruction
    set_mem(1, 0, 0, 32'h40, 0, 4'hF); #1;
    chk("nomem_stall", stall, 0);
    tick();
    chk("nomem_req", bus.req, 0);
    chk("nomem_done", done, 0);
    // zero-wait load
    set_mem(1, 1, 0, 32'h100, 0, 4'hF); #1;
    chk("ld0_idle_stall", stall, 1);
    chk("ld0_idle_bubble", bubble, 1);
    chk("ld0_idle_req", bus.req, 0);
    tick();
    chk("ld0_req", bus.req, 1);
    chk("ld0_we", bus.we, 0);
    chk("ld0_addr", bus.addr, 32'h100);
    chk("ld0_req_stall", stall, 1);
    bus.ack = 1'b1; bus.rdata = 32'hDEADBEEF;
    tick();
    bus.ack = 1'b0; bus.rdata = '0; #1;
    chk("ld0_done_req", bus.req, 0);
    chk("ld0_done_stall", stall, 0);
    chk("ld0_done_bubble", bubble, 0);
    chk("ld0_done", done, 1);
    chk("ld0_fault", fault, 0);
    chk("ld0_data", ld, 32'hDEADBEEF);
    tick();
    set_mem(0, 0, 0, 0, 0, 0); #1;
    chk("ld0_after_done", done, 0);
    chk("ld0_after_stall", stall, 0);
    chk("ld0_after_req", bus.req, 0);
    // store with 3 wait cycles
    set_mem(1, 0, 1, 32'h204, 32'h12345678, 4'hF); #1;
    chk("st_idle_stall", stall, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.ack = 1'b1;
      #1;
      chk("st_req", bus.req, 1);
      chk("st_we", bus.we, 1);
      chk("st_addr", bus.addr, 32'h204);
      chk("st_wdata", bus.wdata, 32'h12345678);
      chk("st_be", bus.be, 4'hF);
      chk("st_stall", stall, 1);
      tick();
    end
    bus.ack = 1'b0; #1;
    chk("st_done", done, 1);
    chk("st_done_stall", stall, 0);
    chk("st_done_req", bus.req, 0);
    chk("st_fault", fault, 0);
    chk("st_ld_held", ld, 32'hDEADBEEF);
    tick();
    set_mem(0, 0, 0, 0, 0, 0);
    // back-to-back loads
    set_mem(1, 1, 0, 32'h10, 0, 4'hF);
    tick();
    bus.ack = 1'b1; bus.rdata = 32'h11; #1;
    chk("b2b1_req", bus.req, 1);
    tick();
    bus.ack = 1'b0; #1;
    chk("b2b1_done", done, 1);
    chk("b2b1_data", ld, 32'h11);
    tick();
    set_mem(1, 1, 0, 32'h20, 0, 4'hF); #1;
    chk("b2b_gap_req", bus.req, 0);
    chk("b2b_gap_stall", stall, 1);
    chk("b2b_gap_done", done, 0);
    tick();
    chk("b2b2_req", bus.req, 1);
    chk("b2b2_addr", bus.addr, 32'h20);
    bus.ack = 1'b1; bus.rdata = 32'h22;
    tick();
    bus.ack = 1'b0; #1;
    chk("b2b2_done", done, 1);
    chk("b2b2_data", ld, 32'h22);
    tick();
    set_mem(0, 0, 0, 0, 0, 0);
    // timeout
    set_mem(1, 1, 0, 32'h300, 0, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_req", bus.req, 1);
      chk("to_stall", stall, 1);
      tick();
    end
    #1;
    chk("to_req_drop", bus.req, 0);
    chk("to_done", done, 1);
    chk("to_fault", fault, 1);
    chk("to_faddr", faddr, 32'h300);
    chk("to_data", ld, 0);
    tick();
    set_mem(0, 0, 0, 0, 0, 0);
    bus.ack = 1'b1; bus.rdata = 32'h55; #1;
    chk("late_ack_req", bus.req, 0);
    chk("late_ack_stall", stall, 0);
    tick();
    bus.ack = 1'b0; #1;
    chk("late_ack_done", done, 0);
    chk("late_ack_fault", fault, 0);
    chk("late_ack_data", ld, 0);
    // clean load after a fault
    set_mem(1, 1, 0, 32'h60, 0, 4'hF);
    tick();
    bus.ack = 1'b1; bus.rdata = 32'h77;
    tick();
    bus.ack = 1'b0; #1;
    chk("ld77_done", done, 1);
    chk("ld77_fault", fault, 0);
    chk("ld77_data", ld, 32'h77);
    chk("ld77_faddr_held", faddr, 32'h300);
    tick();
    set_mem(0, 0, 0, 0, 0, 0);
    // bus error on load
    set_mem(1, 1, 0, 32'hBAD0, 0, 4'hF);
    tick();
    bus.ack = 1'b1; bus.err = 1'b1; bus.rdata = 32'hFFFF;
    tick();
    bus.ack = 1'b0; bus.err = 1'b0; #1;
    chk("err_done", done, 1);
    chk("err_fault", fault, 1);
    chk("err_faddr", faddr, 32'hBAD0);
    chk("err_data", ld, 0);
    tick();
    set_mem(0, 0, 0, 0, 0, 0);
    // read and write both set: handled as store
    set_mem(1, 1, 1, 32'h500, 32'hA5A5, 4'h3);
    tick();
    chk("rw_we", bus.we, 1);
    chk("rw_be", bus.be, 4'h3);
    chk("rw_wdata", bus.wdata, 32'hA5A5);
    bus.ack = 1'b1; bus.rdata = 32'h99;
    tick();
    bus.ack = 1'b0; #1;
    chk("rw_done", done, 1);
    chk("rw_fault", fault, 0);
    chk("rw_data", ld, 0);
    tick();
    set_mem(0, 0, 0, 0, 0, 0);
    // asynchronous reset in the second REQ cycle
    set_mem(1, 1, 0, 32'h400, 0, 4'hF);
    tick();
    chk("ar_req1", bus.req, 1);
    tick();
    rst_n = 1'b0; #1;
    chk("ar_req", bus.req, 0);
    chk("ar_stall", stall, 0);
    chk("ar_done", done, 0);
    #2 bus.ack = 1'b1; bus.rdata = 32'h66;
    tick();
    set_mem(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1; #1;
    chk("ar_rel_stall", stall, 0);
    tick();
    chk("ar_rel_req", bus.req, 0);
    chk("ar_rel_done", done, 0);
    chk("ar_rel_fault", fault, 0);
    chk("ar_rel_data", ld, 0);
    bus.ack = 1'b0;
    tick();
    chk("ar_rel_done2", done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
